// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1/8N2 UART transmitter that pulls bytes from the message memory and skips idle codes
module uart_byte_tx #(
  parameter int         CLK_FREQ  = 50_000_000,
  parameter int         BAUD      = 115200,
  parameter int         STOP_BITS = 1,
  parameter logic [7:0] IDLE_CODE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iTX_EN,
  input  logic [7:0] iTX_DATA,
  output logic       oTX_REQ,
  output logic       oTXD,
  output logic       oBUSY,
  output logic       oBYTE_DONE
);

  localparam int DIVISOR = CLK_FREQ / BAUD;
  localparam int CNT_W   = $clog2(DIVISOR) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, STOP} stateType;

  stateType         state, stateNext;
  logic [CNT_W-1:0] baudCnt, baudCntNext;
  logic [2:0]       bitIdx, bitIdxNext;
  logic [7:0]       shiftReg, shiftRegNext;
  logic             skipGap, skipGapNext;
  logic             armed;
  logic             txdNext, reqNext, busyNext, doneNext;

  // State, datapath and output flops; outputs are registered copies of the next-state decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baudCnt    <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      skipGap    <= 1'b0;
      armed      <= 1'b0;
      oTXD       <= 1'b1;
      oTX_REQ    <= 1'b0;
      oBUSY      <= 1'b0;
      oBYTE_DONE <= 1'b0;
    end else begin
      state      <= stateNext;
      baudCnt    <= baudCntNext;
      bitIdx     <= bitIdxNext;
      shiftReg   <= shiftRegNext;
      skipGap    <= skipGapNext;
      armed      <= 1'b1;
      oTXD       <= txdNext;
      oTX_REQ    <= reqNext;
      oBUSY      <= busyNext;
      oBYTE_DONE <= doneNext;
    end
  end

  // Next-state sequencing; WAIT also hosts the DIVISOR-cycle gap when an idle code is fetched
  always_comb begin
    stateNext    = state;
    baudCntNext  = baudCnt;
    bitIdxNext   = bitIdx;
    shiftRegNext = shiftReg;
    skipGapNext  = skipGap;
    case (state)
      IDLE: begin
        baudCntNext = '0;
        // armed keeps IDLE for at least one full cycle after reset release
        if (iTX_EN && armed) stateNext = REQ;
      end
      REQ: begin
        baudCntNext = '0;
        skipGapNext = 1'b0;
        stateNext   = WAIT;
      end
      WAIT: begin
        if (!skipGap) begin
          if (baudCnt == CNT_ONE) begin
            shiftRegNext = iTX_DATA;
            baudCntNext  = '0;
            if (iTX_DATA == IDLE_CODE) skipGapNext = 1'b1;
            else                       stateNext   = START;
          end else begin
            baudCntNext = baudCnt + 1'b1;
          end
        end else if (baudCnt == CNT_LAST) begin
          baudCntNext = '0;
          skipGapNext = 1'b0;
          stateNext   = IDLE;
        end else begin
          baudCntNext = baudCnt + 1'b1;
        end
      end
      START: begin
        if (baudCnt == CNT_LAST) begin
          baudCntNext = '0;
          bitIdxNext  = '0;
          stateNext   = DATA;
        end else begin
          baudCntNext = baudCnt + 1'b1;
        end
      end
      DATA: begin
        if (baudCnt == CNT_LAST) begin
          baudCntNext  = '0;
          shiftRegNext = {1'b0, shiftReg[7:1]};
          if (bitIdx == 3'd7) begin
            bitIdxNext = '0;
            stateNext  = STOP;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
          end
        end else begin
          baudCntNext = baudCnt + 1'b1;
        end
      end
      STOP: begin
        // bitIdx counts stop bits here so 8N2 needs no extra state
        if (baudCnt == CNT_LAST) begin
          baudCntNext = '0;
          if (bitIdx == STOP_LAST) begin
            bitIdxNext = '0;
            stateNext  = iTX_EN ? REQ : IDLE;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
          end
        end else begin
          baudCntNext = baudCnt + 1'b1;
        end
      end
      default: begin
        stateNext   = IDLE;
        baudCntNext = '0;
        bitIdxNext  = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state they describe
  always_comb begin
    txdNext  = 1'b1;
    reqNext  = (stateNext == REQ);
    busyNext = (stateNext != IDLE);
    doneNext = (stateNext == STOP) && (baudCntNext == CNT_LAST) && (bitIdxNext == STOP_LAST);
    case (stateNext)
      START:   txdNext = 1'b0;
      DATA:    txdNext = shiftRegNext[0];
      default: txdNext = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb/tb_uart_byte_tx.sv - directed and randomized bench for uart_byte_tx with a line-level reference model
module tb_uart_byte_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       en0, en1, en2;
  logic [7:0] data0, data1, data2;
  logic       req0, txd0, busy0, done0;
  logic       req1, txd1, busy1, done1;
  logic       req2, txd2, busy2, done2;

  int   sel;
  logic reqS, txdS, busyS, doneS;
  int   nChecks = 0;
  int   nFails = 0;
  int   lastBitLen;

  always #5 clk = ~clk;

  uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(1), .IDLE_CODE(8'hFF)) dut0 (
    .clk(clk), .reset(reset), .iTX_EN(en0), .iTX_DATA(data0),
    .oTX_REQ(req0), .oTXD(txd0), .oBUSY(busy0), .oBYTE_DONE(done0));

  uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(2), .IDLE_CODE(8'hFF)) dut1 (
    .clk(clk), .reset(reset), .iTX_EN(en1), .iTX_DATA(data1),
    .oTX_REQ(req1), .oTXD(txd1), .oBUSY(busy1), .oBYTE_DONE(done1));

  uart_byte_tx dut2 (
    .clk(clk), .reset(reset), .iTX_EN(en2), .iTX_DATA(data2),
    .oTX_REQ(req2), .oTXD(txd2), .oBUSY(busy2), .oBYTE_DONE(done2));

  always_comb begin
    reqS = req0; txdS = txd0; busyS = busy0; doneS = done0;
    case (sel)
      1: begin reqS = req1; txdS = txd1; busyS = busy1; doneS = done1; end
      2: begin reqS = req2; txdS = txd2; busyS = busy2; doneS = done2; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setEn(input logic v);
    case (sel)
      1: en1 = v;
      2: en2 = v;
      default: en0 = v;
    endcase
  endtask

  task automatic setData(input logic [7:0] v);
    case (sel)
      1: data1 = v;
      2: data2 = v;
      default: data0 = v;
    endcase
  endtask

  // returns at the negedge where oTX_REQ is seen; lat = -1 on timeout
  task automatic waitReq(input int maxC, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!reqS && lat < maxC);
    if (!reqS) lat = -1;
  endtask

  // Called at the oTX_REQ cycle. Expected line level in frame cycle k is derived from the bit slot k/div.
  task automatic checkFrame(input string tag, input logic [7:0] b, input int div,
                            input int stopBits, input int dropAt);
    int   errs, reqErrs, doneCnt, doneAt, fallAt, riseAt, frameLen, idx;
    logic exp, prev;
    errs = 0; reqErrs = 0; doneCnt = 0; doneAt = -1; fallAt = -1; riseAt = -1; prev = 1'b1;
    if (txdS !== 1'b1) errs++;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      if (txdS !== 1'b1 || reqS !== 1'b0 || busyS !== 1'b1) errs++;
    end
    frameLen = (9 + stopBits) * div;
    for (int k = 0; k < frameLen; k++) begin
      @(negedge clk);
      if (k == dropAt) setEn(1'b0);
      idx = k / div;
      if (idx == 0)      exp = 1'b0;
      else if (idx <= 8) exp = b[idx-1];
      else               exp = 1'b1;
      if (txdS !== exp) errs++;
      if (busyS !== 1'b1) errs++;
      if (reqS !== 1'b0) reqErrs++;
      if (doneS === 1'b1) begin doneCnt++; doneAt = k; end
      if (prev === 1'b1 && txdS === 1'b0 && fallAt < 0) fallAt = k;
      if (prev === 1'b0 && txdS === 1'b1 && riseAt < 0) riseAt = k;
      prev = txdS;
    end
    lastBitLen = riseAt - fallAt;
    check({tag, "_line"}, errs, 0);
    check({tag, "_req_in_frame"}, reqErrs, 0);
    check({tag, "_done_count"}, doneCnt, 1);
    check({tag, "_done_cycle"}, doneAt, frameLen - 1);
  endtask

  logic [7:0] stream[$];
  logic [7:0] b;
  int         lat, errs, doneSeen;

  initial begin
    reset = 1'b0;
    en0 = 0; en1 = 0; en2 = 0;
    data0 = 0; data1 = 0; data2 = 0;
    sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check($sformatf("reset_txd%0d", s), txdS, 1);
      check($sformatf("reset_req%0d", s), reqS, 0);
      check($sformatf("reset_busy%0d", s), busyS, 0);
      check($sformatf("reset_done%0d", s), doneS, 0);
    end
    sel = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // basic byte, enable pulsed for one cycle
    setData(8'h63);
    setEn(1'b1);
    waitReq(5, lat);
    setEn(1'b0);
    check("basic_req_lat", lat, 1);
    checkFrame("basic", 8'h63, 10, 1, -1);
    @(negedge clk);
    check("basic_busy_after", busyS, 0);
    check("basic_txd_after", txdS, 1);
    errs = 0;
    repeat (20) begin @(negedge clk); if (reqS !== 1'b0) errs++; end
    check("basic_no_more_req", errs, 0);

    // stream: "cur", an idle code, then random bytes; enable drops in bit 3 of the last frame
    stream = '{8'h63, 8'h75, 8'h72, 8'hFF};
    for (int i = 0; i < 4; i++) stream.push_back(8'($urandom_range(0, 254)));
    setEn(1'b1);
    waitReq(5, lat);
    check("stream_first_req", lat, 1);
    for (int i = 0; i < stream.size(); i++) begin
      setData(stream[i]);
      if (stream[i] == 8'hFF) begin
        errs = 0;
        for (int c = 1; c < 13; c++) begin
          @(negedge clk);
          if (txdS !== 1'b1 || busyS !== 1'b1 || reqS !== 1'b0) errs++;
        end
        check("skip_gap", errs, 0);
        @(negedge clk);
        check("skip_idle_busy", busyS, 0);
        check("skip_idle_txd", txdS, 1);
        waitReq(5, lat);
        check("skip_next_req", lat, 1);
      end else if (i == stream.size() - 1) begin
        checkFrame($sformatf("stream%0d", i), stream[i], 10, 1, 4 * 10 + 3);
        @(negedge clk);
        check("drop_busy_after_done", busyS, 0);
        errs = 0;
        repeat (30) begin @(negedge clk); if (reqS !== 1'b0) errs++; end
        check("drop_no_req", errs, 0);
      end else begin
        checkFrame($sformatf("stream%0d", i), stream[i], 10, 1, -1);
        waitReq(5, lat);
        check($sformatf("stream%0d_gap", i), lat, 1);
      end
    end

    // two stop bits
    sel = 1;
    setData(8'h0A);
    setEn(1'b1);
    waitReq(5, lat);
    setEn(1'b0);
    check("stop2_req_lat", lat, 1);
    checkFrame("stop2", 8'h0A, 10, 2, -1);
    @(negedge clk);
    check("stop2_busy_after", busyS, 0);

    // reset during data bit 5, then full resend
    sel = 0;
    b = 8'($urandom_range(0, 254));
    setData(b);
    setEn(1'b1);
    waitReq(5, lat);
    check("rst_first_req", lat, 1);
    doneSeen = 0;
    repeat (2 + 6 * 10 + 3) begin @(negedge clk); if (doneS === 1'b1) doneSeen++; end
    #2 reset = 1'b0;
    #1;
    check("rst_async_txd", txdS, 1);
    check("rst_async_busy", busyS, 0);
    check("rst_async_done", doneS, 0);
    repeat (3) begin @(negedge clk); if (doneS === 1'b1) doneSeen++; end
    check("rst_no_done", doneSeen, 0);
    reset = 1'b1;
    waitReq(10, lat);
    check("rst_req_at_least_2", (lat >= 2) ? 1 : 0, 1);
    checkFrame("rst_resend", b, 10, 1, 5);
    @(negedge clk);
    check("rst_busy_after", busyS, 0);

    // default parameters: bit time 50_000_000/115200 = 434 cycles
    sel = 2;
    setData(8'h31);
    setEn(1'b1);
    waitReq(5, lat);
    setEn(1'b0);
    check("dflt_req_lat", lat, 1);
    checkFrame("dflt", 8'h31, 434, 1, -1);
    check("dflt_bit_len", lastBitLen, 434);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
